// File: rtl/elevator_scan_scheduler.sv
// rtl/elevator_scan_scheduler.sv - SCAN elevator scheduler: request bitmap, car position, direction, door
// Optional build macro: EMERGENCY_RECALL_EN (adds recall input; car returns to floor 1 and holds door)
module elevator_scan_scheduler #(
  parameter int FLOORS      = 16,
  parameter int FW          = 4,
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EMERGENCY_RECALL_EN
  input  logic              recall,
`endif
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic              req_ready,
  output logic              req_err,
  output logic [FW-1:0]     cur_floor,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic [FLOORS-1:0] pending,
  output logic              idle
);

  localparam int MCW = $clog2(MOVE_CYCLES + 1);
  localparam int DCW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     cur_floor_q, cur_floor_d;
  logic              dir_up_q, dir_up_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [MCW-1:0]    move_cnt_q, move_cnt_d;
  logic [DCW-1:0]    door_cnt_q, door_cnt_d;
  logic              req_err_q, req_err_d;

  logic              req_ok, req_here, can_step, step_hit;
  logic              up_any_q, dn_any_q, up_any_in, dn_any_in;
  logic [FW-1:0]     step_floor;
  logic [FLOORS-1:0] req_hot, step_hot, pend_in;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i > int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 1; i < FLOORS; i++)
      if (i < int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [FLOORS-1:0] r;
    r = '0;
    for (int i = 1; i < FLOORS; i++)
      r[i] = (int'(f) == i);
    return r;
  endfunction

`ifdef EMERGENCY_RECALL_EN
  assign req_ready = !recall;
`else
  assign req_ready = 1'b1;
`endif

  always_comb begin
    req_ok     = req_valid && req_ready && (req_floor != '0) && (int'(req_floor) < FLOORS);
    req_hot    = onehot(req_floor);
    // A call for the floor the car stands at (door open or idle) is served in place, never queued.
    req_here   = req_ok && (req_floor == cur_floor_q) && (state_q != S_MOVE);
    pend_in    = pending_q | ((req_ok && !req_here) ? req_hot : '0);
    up_any_q   = any_above(pending_q, cur_floor_q);
    dn_any_q   = any_below(pending_q, cur_floor_q);
    up_any_in  = any_above(pend_in, cur_floor_q);
    dn_any_in  = any_below(pend_in, cur_floor_q);
    can_step   = dir_up_q ? (int'(cur_floor_q) < FLOORS - 1) : (int'(cur_floor_q) > 1);
    step_floor = can_step ? (dir_up_q ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1) : cur_floor_q;
    step_hot   = onehot(step_floor);
    step_hit   = |(pend_in & step_hot);

    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    pending_d   = pend_in;
    move_cnt_d  = move_cnt_q;
    door_cnt_d  = door_cnt_q;
    req_err_d   = req_valid && req_ready && !req_ok;

    case (state_q)
      S_IDLE: begin
        move_cnt_d = '0;
        if (req_here) begin
          state_d    = S_DOOR;
          door_cnt_d = DCW'(DOOR_CYCLES);
        end else if (up_any_q && dn_any_q) begin
          state_d = S_MOVE;
        end else if (up_any_q) begin
          state_d  = S_MOVE;
          dir_up_d = 1'b1;
        end else if (dn_any_q) begin
          state_d  = S_MOVE;
          dir_up_d = 1'b0;
        end
      end
      S_MOVE: begin
        if (move_cnt_q == MCW'(MOVE_CYCLES - 1)) begin
          move_cnt_d  = '0;
          cur_floor_d = step_floor;
          if (step_hit) begin
            pending_d  = pend_in & ~step_hot;
            state_d    = S_DOOR;
            door_cnt_d = DCW'(DOOR_CYCLES);
          end
        end else begin
          move_cnt_d = move_cnt_q + 1'b1;
        end
      end
      S_DOOR: begin
        if (req_here) begin
          door_cnt_d = DCW'(DOOR_CYCLES);
        end else if (door_cnt_q <= DCW'(1)) begin
          door_cnt_d = '0;
          move_cnt_d = '0;
          if (dir_up_q ? up_any_in : dn_any_in) begin
            state_d = S_MOVE;
          end else if (dir_up_q ? dn_any_in : up_any_in) begin
            state_d  = S_MOVE;
            dir_up_d = !dir_up_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          door_cnt_d = door_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef EMERGENCY_RECALL_EN
    // Recall finishes any step in progress, then heads straight down to floor 1 and parks door-open.
    if (recall) begin
      pending_d = '0;
      case (state_q)
        S_MOVE: begin
          state_d = S_MOVE;
          if (move_cnt_q == MCW'(MOVE_CYCLES - 1)) begin
            move_cnt_d  = '0;
            cur_floor_d = step_floor;
            dir_up_d    = 1'b0;
            if (step_floor == FW'(1)) begin
              state_d    = S_DOOR;
              door_cnt_d = DCW'(DOOR_CYCLES);
            end
          end else begin
            move_cnt_d = move_cnt_q + 1'b1;
          end
        end
        default: begin
          move_cnt_d = '0;
          if (cur_floor_q == FW'(1)) begin
            state_d    = S_DOOR;
            door_cnt_d = DCW'(DOOR_CYCLES);
          end else begin
            state_d  = S_MOVE;
            dir_up_d = 1'b0;
          end
        end
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_floor_q <= FW'(1);
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      move_cnt_q  <= '0;
      door_cnt_q  <= '0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      move_cnt_q  <= move_cnt_d;
      door_cnt_q  <= door_cnt_d;
      req_err_q   <= req_err_d;
    end
  end

  assign req_err   = req_err_q;
  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = (state_q == S_MOVE);
  assign door_open = (state_q == S_DOOR);
  assign pending   = pending_q;
  assign idle      = (state_q == S_IDLE) && (pending_q == '0);

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// tb/tb_elevator_scan_scheduler.sv - random and directed stimulus against a floor-level car model
module tb_elevator_scan_scheduler;
  localparam int FLOORS = 12;
  localparam int FW     = 4;
  localparam int MOVE_C = 3;
  localparam int DOOR_C = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [FW-1:0]     req_floor = '0;
  logic              req_ready, req_err, dir_up, moving, door_open, idle;
  logic [FW-1:0]     cur_floor;
  logic [FLOORS-1:0] pending;
`ifdef EMERGENCY_RECALL_EN
  logic              recall = 1'b0;
`endif

  elevator_scan_scheduler #(
    .FLOORS(FLOORS), .FW(FW), .MOVE_CYCLES(MOVE_C), .DOOR_CYCLES(DOOR_C)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef EMERGENCY_RECALL_EN
    .recall(recall),
`endif
    .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready), .req_err(req_err),
    .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving), .door_open(door_open),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Car model: what the car is doing, where it is, and how long until the current activity ends.
  localparam int AT_REST = 0, TRAVEL = 1, DOORS = 2;
  int                activity;
  int                floor_no;
  bit                going_up;
  logic [FLOORS-1:0] calls;
  int                travelled;
  int                door_left;
  bit                err_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit calls_between(input logic [FLOORS-1:0] v, input int lo, input int hi);
    bit r = 0;
    for (int i = lo; i <= hi; i++)
      if (i >= 1 && i < FLOORS && v[i]) r = 1;
    return r;
  endfunction

  task automatic model_step(input bit r, input bit v, input int f);
    bit ok, here, ahead, behind, above, below;
    logic [FLOORS-1:0] add;
    if (r) begin
      activity = AT_REST; floor_no = 1; going_up = 1; calls = '0;
      travelled = 0; door_left = 0; err_pulse = 0;
      return;
    end
    ok        = v && f >= 1 && f < FLOORS;
    err_pulse = v && !ok;
    here      = ok && f == floor_no && activity != TRAVEL;
    add       = '0;
    if (ok && !here) add[f] = 1'b1;
    case (activity)
      AT_REST: begin
        above = calls_between(calls, floor_no + 1, FLOORS - 1);
        below = calls_between(calls, 1, floor_no - 1);
        travelled = 0;
        if (here) begin
          activity = DOORS; door_left = DOOR_C;
        end else if (above || below) begin
          activity = TRAVEL;
          if (!(above && below)) going_up = above;
        end
        calls |= add;
      end
      TRAVEL: begin
        calls |= add;
        travelled++;
        if (travelled == MOVE_C) begin
          travelled = 0;
          floor_no += going_up ? 1 : -1;
          if (calls[floor_no]) begin
            calls[floor_no] = 1'b0;
            activity = DOORS; door_left = DOOR_C;
          end
        end
      end
      default: begin
        if (here) begin
          door_left = DOOR_C;
        end else begin
          calls |= add;
          door_left--;
          if (door_left == 0) begin
            above  = calls_between(calls, floor_no + 1, FLOORS - 1);
            below  = calls_between(calls, 1, floor_no - 1);
            ahead  = going_up ? above : below;
            behind = going_up ? below : above;
            travelled = 0;
            if (ahead) activity = TRAVEL;
            else if (behind) begin activity = TRAVEL; going_up = !going_up; end
            else activity = AT_REST;
          end
        end
      end
    endcase
  endtask

  task automatic tick(input bit r, input bit v, input int f);
    @(negedge clk);
    rst = r; req_valid = v; req_floor = FW'(f);
    check("req_ready", req_ready, 1);
    @(posedge clk);
    model_step(r, v, f);
    #1;
    check("cur_floor", cur_floor, floor_no);
    check("dir_up", dir_up, going_up);
    check("moving", moving, activity == TRAVEL);
    check("door_open", door_open, activity == DOORS);
    check("pending", pending, calls);
    check("idle", idle, activity == AT_REST && calls == '0);
    check("req_err", req_err, err_pulse);
  endtask

  task automatic drain();
    int n = 0;
    while (!idle && n < 500) begin tick(0, 0, 0); n++; end
    check("drain_idle", idle, 1);
  endtask

  task automatic run_until_floor(input int f);
    int n = 0;
    while (cur_floor != FW'(f) && n < 300) begin tick(0, 0, 0); n++; end
    check("reach_floor", cur_floor, f);
  endtask

  initial begin
    int n, d;
    tick(1, 0, 0);
    tick(0, 0, 0);
    check("rst_floor", cur_floor, 1);
    check("rst_idle", idle, 1);

    // Single call from rest: 4 floors away arrives 13 cycles after the accept edge.
    tick(0, 1, 5);
    n = 0;
    while (!door_open && n < 100) begin tick(0, 0, 0); n++; end
    check("arrive_latency", n, 13);
    check("arrive_floor", cur_floor, 5);
    d = 0;
    while (door_open && d < 50) begin d++; tick(0, 0, 0); end
    check("door_length", d, DOOR_C);
    check("idle_after", idle, 1);

    // Intermediate call picked up on the way.
    tick(1, 0, 0); tick(0, 1, 8); run_until_floor(2); tick(0, 1, 4); drain();
    check("serve_8_last", cur_floor, 8);

    // Sweep finishes upward before reversing.
    tick(1, 0, 0); tick(0, 1, 3); drain(); tick(0, 1, 9); run_until_floor(5);
    tick(0, 1, 2); drain();
    check("serve_2_last", cur_floor, 2);

    // Invalid floors.
    tick(1, 0, 0); tick(0, 1, 0); tick(0, 1, 15); tick(0, 1, FLOORS); tick(0, 0, 0);
    check("invalid_idle", idle, 1);

    // Door extension by repeated calls at the same floor.
    tick(1, 0, 0); tick(0, 1, 6);
    n = 0;
    while (!door_open && n < 100) begin tick(0, 0, 0); n++; end
    tick(0, 1, 6); tick(0, 0, 0); tick(0, 1, 6);
    d = 0;
    while (door_open && d < 50) begin d++; tick(0, 0, 0); end
    check("door_extend", d, DOOR_C);

    // Reset in mid travel.
    tick(1, 0, 0); tick(0, 1, 7); tick(0, 1, 9); run_until_floor(4); tick(0, 0, 0);
    tick(1, 0, 0);
    check("midrst_floor", cur_floor, 1);
    check("midrst_pending", pending, 0);
    check("midrst_moving", moving, 0);
    tick(0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/elevator_scan_scheduler.md
Name: elevator_scan_scheduler

Overview:
Single-car elevator scheduler using the SCAN (sweep) algorithm. It holds a pending-floor bitmap fed by a valid/ready request port, picks the next stop, and sequences car position, travel direction and door. It sits between the call-button/request logic and the car motor and door drivers. Floor code 0 is reserved as IDLE/invalid; legal floors are 1..FLOORS-1.

Parameters:
FLOORS, 16, number of floor codes including reserved 0; legal floors 1..FLOORS-1
FW, 4, floor code width; FLOORS <= 2**FW
MOVE_CYCLES, 3, clocks to travel one floor (>=1)
DOOR_CYCLES, 4, clocks door stays open per stop (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_floor  in  FW  requested floor
req_ready  out  1  request accepted when req_valid && req_ready
req_err  out  1  one-cycle pulse: accepted request was floor 0 or >= FLOORS, dropped
cur_floor  out  FW  current car floor
dir_up  out  1  sweep direction, 1 = up
moving  out  1  car travelling (MOVE state)
door_open  out  1  door open (DOOR state)
pending  out  FLOORS  pending-stop bitmap; bit 0 always 0
idle  out  1  IDLE state and pending == 0

Behaviour:
- Reset, synchronous, overrides all else: state=IDLE, cur_floor=1, dir_up=1, pending=0, counters=0, moving=0, door_open=0, req_err=0, req_ready=1. Mid-travel or mid-door reset aborts immediately; cur_floor snaps to 1.
- req_ready=1 outside reset. Accept sets pending[req_floor] at the next edge. Duplicate requests are idempotent.
- Invalid floor: no bitmap change; req_err=1 for exactly the next cycle.
- Request for cur_floor while in DOOR: bit not set; door_cnt reloads to DOOR_CYCLES (door extends).
- Request for cur_floor while in IDLE: bit not set; go to DOOR next cycle.
- States: IDLE, MOVE, DOOR.
- IDLE:
  - If there are pending floors above and below, keep dir_up and enter MOVE.
  - If pending only above, set dir_up=1 and enter MOVE.
  - If pending only below, set dir_up=0 and enter MOVE.
  - Otherwise stay in IDLE.
  - move_cnt=0 on entry to MOVE.
- MOVE:
  - moving=1; move_cnt increments each cycle.
  - When move_cnt==MOVE_CYCLES-1, cur_floor steps by ±1 and move_cnt clears.
  - If pending[new floor], or a request for that floor is accepted in the same cycle, clear the bit and enter DOOR with door_cnt=DOOR_CYCLES. Otherwise continue.
  - cur_floor never leaves 1..FLOORS-1. Stepping past the last pending floor is impossible by construction.
- DOOR:
  - door_open=1; door_cnt decrements.
  - On reaching 0:
    - If pending ahead in dir_up, go to MOVE.
    - Else if pending behind, flip dir_up and go to MOVE.
    - Else go to IDLE.
- A request set on the same edge as the DOOR→next decision is included in that decision. Bitmap set and clear in the same cycle for the same floor: clear wins (stop served).
- Latency: IDLE request to floor f>cur:
  - Accept edge: T.
  - Enter MOVE: T+1.
  - Arrive (door_open=1): T+1+|f-cur|*MOVE_CYCLES.

Optional Feature:
- Macro: EMERGENCY_RECALL_EN.
- Defined:
  - Adds input `recall` (1 bit).
  - While recall=1: req_ready=0; pending cleared.
  - Car completes the current floor step, then drives to floor 1 (dir_up=0) with no intermediate stops.
  - At floor 1, door_open=1 and held while recall=1.
  - On recall deassert, the door runs DOOR_CYCLES, then goes to IDLE.
- Undefined: no recall port; req_ready tied 1 outside reset.

Test Plan:
1. Reset, cur_floor=1; request 5 → accept at T, moving T+1, cur_floor=5 and door_open=1 at T+13 (MOVE_CYCLES=3), door_open 4 cycles, then idle=1.
2. Car at 1; request 8, then request 4 while passing floor 2 → stops at 4 (door), then 8; pending[4] and pending[8] clear on each arrival.
3. Car moving up from 3 to 9; request 2 → serves 9 first, dir_up flips to 0, then serves 2.
4. Request floor 0 and floor 15 with FLOORS=12 → req_err pulse each, pending unchanged; car stays IDLE.
5. Door open at 6; request 6 twice, 2 cycles apart → door_open extends to 4 cycles after the last request; pending[6] never set.
6. Assert rst mid-MOVE between floors 4 and 5 with pending={7,9} → next cycle cur_floor=1, pending=0, moving=0, idle=1. With EMERGENCY_RECALL_EN: recall during travel up at 6 → car reverses, reaches 1, door held open, req_ready=0.
